conv1d_stream_array: RTL and testbench

Parametrised, streaming 1-D convolution engine built as a transposed-form, weight-stationary systolic chain of `TAPS` processing elements. Input samples are broadcast to every PE over a valid/ready stream. The block emits the full convolution of each frame, `LEN+TAPS-1` outputs, by automatically flushing zeros after the last input. It replaces fixed-size, free-running convolution arrays in the accelerator path with a backpressure-aware unit that can be sized per instance.

---
 rtl/conv1d_pkg.sv | 45 ++++
 rtl/conv1d_stream_array_if.sv | 48 ++++
 rtl/conv1d_pe.sv | 50 +++++
 rtl/conv1d_stream_array.sv | 146 ++++++++++++++
 tb/tb_conv1d_stream_array.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared types and helpers for the conv1d_stream_array slice.
//   state_t     - FSM encoding (IDLE, RUN, FLUSH)
//   acc_width   - accumulator width from sample/weight widths and tap count
//   idx_width   - weight index width, at least 1 bit so TAPS=1 still builds
//   sat_narrow  - signed clamp of a wide value into an outW-bit signed range
//                 (only referenced when CONV1D_SAT_EN is defined)
package conv1d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Working width for the saturation helper; accumulators wider than this
  // are not supported when saturation is enabled.
  localparam int SAT_W = 128;

  function automatic int acc_width(input int dw, input int ww, input int taps);
    return dw + ww + $clog2(taps);
  endfunction

  function automatic int idx_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_narrow(
    input logic signed [SAT_W-1:0] v,
    input int                      outW
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    // All-ones shifted down leaves 2^(outW-1)-1; its complement is -2^(outW-1).
    hi = '1;
    hi = hi >> (SAT_W - outW + 1);
    lo = ~hi;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/conv1d_stream_array_if.sv
// conv1d_stream_array_if: weight-write port plus input/output sample streams.
//   master modport: the producer/consumer side (drives weights, samples,
//                   out_ready; observes in_ready and the output stream)
//   slave  modport: the convolution engine
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high. The producer holds data/last stable while valid is high and
// ready is low; valid may not depend on ready.
interface conv1d_stream_array_if
  import conv1d_pkg::*;
#(
  parameter int TAPS  = 10,
  parameter int DW    = 32,
  parameter int WW    = 32,
  parameter int OUT_W = 32
);
  localparam int IDX_W = idx_width(TAPS);

  logic                    w_we;
  logic [IDX_W-1:0]        w_idx;
  logic signed [WW-1:0]    w_data;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [DW-1:0]    in_data;
  logic                    in_last;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_last;

  modport master (
    output w_we, w_idx, w_data,
    output in_valid, in_data, in_last,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready
  );

  modport slave (
    input  w_we, w_idx, w_data,
    input  in_valid, in_data, in_last,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready
  );

endinterface

// File: rtl/conv1d_pe.sv
// conv1d_pe: one transposed-form processing element.
//   clk, rst  - clock, synchronous active-high reset (clears p_out only)
//   sample    - broadcast input sample (zero during flush)
//   adv       - advance strobe: p_out <= w*sample + p_in
//   w_en      - load w_data into this PE's weight register
//   w_data    - weight value
//   p_in      - partial sum from the next PE (zero for the last PE)
//   p_out     - this PE's registered partial sum
module conv1d_pe
  import conv1d_pkg::*;
#(
  parameter int DW    = 32,
  parameter int WW    = 32,
  parameter int ACC_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DW-1:0]    sample,
  input  logic                    adv,
  input  logic                    w_en,
  input  logic signed [WW-1:0]    w_data,
  input  logic signed [ACC_W-1:0] p_in,
  output logic signed [ACC_W-1:0] p_out
);

  // Weights survive rst; they power up as zero.
  logic signed [WW-1:0]    weight = '0;
  logic signed [WW-1:0]    effWeight;
  logic signed [ACC_W-1:0] prod;

  // A weight written in the same cycle as a frame's first sample is
  // forwarded so that sample already sees the new coefficient.
  assign effWeight = w_en ? w_data : weight;
  assign prod      = ACC_W'(sample) * ACC_W'(effWeight);

  always_ff @(posedge clk) begin
    if (w_en) begin
      weight <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_out <= '0;
    end else if (adv) begin
      p_out <= prod + p_in;
    end
  end

endmodule

// File: rtl/conv1d_stream_array.sv
// conv1d_stream_array: streaming full 1-D convolution, TAPS-deep
// weight-stationary transposed chain with automatic zero flush.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - conv1d_stream_array_if.slave (weights, input and output streams)
//   busy      - high while a frame is in RUN or FLUSH
//   dbgState  - current FSM state
// Optional build macro CONV1D_SAT_EN: clamp results that do not fit OUT_W
// signed; otherwise the low OUT_W bits are presented (two's-complement wrap).
module conv1d_stream_array
  import conv1d_pkg::*;
#(
  parameter int TAPS  = 10,
  parameter int DW    = 32,
  parameter int WW    = 32,
  parameter int OUT_W = 32
) (
  input  logic   clk,
  input  logic   rst,
  conv1d_stream_array_if.slave bus,
  output logic   busy,
  output state_t dbgState
);

  localparam int ACC_W     = acc_width(DW, WW, TAPS);
  localparam int IDX_W     = idx_width(TAPS);
  localparam int CNT_W     = (TAPS > 2) ? $clog2(TAPS - 1) : 1;
  localparam int FLUSH_END = (TAPS > 1) ? TAPS - 2 : 0;

  state_t                  state;
  state_t                  stateNext;
  logic [CNT_W-1:0]        flushCnt;
  logic [CNT_W-1:0]        cntNext;
  logic                    outValid;
  logic                    outLast;
  logic                    inReady;
  logic                    inFire;
  logic                    adv;
  logic                    lastBeat;
  logic signed [DW-1:0]    sample;
  logic [TAPS-1:0]         wEn;
  logic signed [ACC_W-1:0] pChain [0:TAPS];

  // Output slot is free when empty or being drained this cycle.
  assign inReady  = !rst && (state != FLUSH) && (!outValid || bus.out_ready);
  assign inFire   = bus.in_valid && inReady;
  assign adv      = (!outValid || bus.out_ready) && (inFire || state == FLUSH);
  assign sample   = (state == FLUSH) ? '0 : bus.in_data;
  // Only meaningful when adv is high; outside FLUSH adv implies a fire.
  assign lastBeat = (state == FLUSH && flushCnt == CNT_W'(FLUSH_END)) ||
                    (TAPS == 1 && bus.in_last);

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_last  = outLast;
  assign busy          = (state != IDLE);
  assign dbgState      = state;

  // PE chain: PE k consumes p[k+1]; p[TAPS] is the implicit zero.
  // p[0] is the complete y[n] and doubles as the output data register.
  assign pChain[TAPS] = '0;

  for (genvar k = 0; k < TAPS; k++) begin : g_pe
    assign wEn[k] = bus.w_we && (state == IDLE) && (bus.w_idx == IDX_W'(k));

    conv1d_pe #(
      .DW    (DW),
      .WW    (WW),
      .ACC_W (ACC_W)
    ) uPe (
      .clk    (clk),
      .rst    (rst),
      .sample (sample),
      .adv    (adv),
      .w_en   (wEn[k]),
      .w_data (bus.w_data),
      .p_in   (pChain[k+1]),
      .p_out  (pChain[k])
    );
  end

`ifdef CONV1D_SAT_EN
  if (OUT_W < ACC_W) begin : g_sat
    assign bus.out_data = OUT_W'(sat_narrow(SAT_W'(pChain[0]), OUT_W));
  end else begin : g_ext
    assign bus.out_data = OUT_W'(pChain[0]);
  end
`else
  // Signed cast sign-extends when widening and keeps the low bits when narrowing.
  assign bus.out_data = OUT_W'(pChain[0]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      flushCnt <= '0;
    end else begin
      state    <= stateNext;
      flushCnt <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = flushCnt;
    case (state)
      IDLE, RUN: begin
        if (inFire) begin
          cntNext = '0;
          if (bus.in_last) begin
            stateNext = (TAPS > 1) ? FLUSH : IDLE;
          end else begin
            stateNext = RUN;
          end
        end
      end
      FLUSH: begin
        if (adv) begin
          if (flushCnt == CNT_W'(FLUSH_END)) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else begin
            cntNext = flushCnt + CNT_W'(1);
          end
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end else if (adv) begin
      outValid <= 1'b1;
      outLast  <= lastBeat;
    end else if (bus.out_ready) begin
      outValid <= 1'b0;
      outLast  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv1d_stream_array.sv
// tb_conv1d_stream_array: directed bench for conv1d_stream_array.
// Three instances: A (TAPS=3, 32-bit), B (TAPS=3, DW=WW=8, OUT_W=16) for
// narrowing, C (TAPS=1). Expected {last,data} beats are queued when stimulus
// is issued; per-instance monitors pop and compare on each accepted beat.
module tb_conv1d_stream_array;
  import conv1d_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv1d_stream_array_if #(.TAPS(3), .DW(32), .WW(32), .OUT_W(32)) busA ();
  conv1d_stream_array_if #(.TAPS(3), .DW(8),  .WW(8),  .OUT_W(16)) busB ();
  conv1d_stream_array_if #(.TAPS(1), .DW(32), .WW(32), .OUT_W(32)) busC ();

  logic   busyA, busyB, busyC;
  state_t stateA, stateB, stateC;

  conv1d_stream_array #(.TAPS(3), .DW(32), .WW(32), .OUT_W(32)) dutA (
    .clk(clk), .rst(rst), .bus(busA), .busy(busyA), .dbgState(stateA));
  conv1d_stream_array #(.TAPS(3), .DW(8), .WW(8), .OUT_W(16)) dutB (
    .clk(clk), .rst(rst), .bus(busB), .busy(busyB), .dbgState(stateB));
  conv1d_stream_array #(.TAPS(1), .DW(32), .WW(32), .OUT_W(32)) dutC (
    .clk(clk), .rst(rst), .bus(busC), .busy(busyC), .dbgState(stateC));

  int total = 0;
  int bad   = 0;

  logic [32:0] expQA[$];
  logic [16:0] expQB[$];
  logic [32:0] expQC[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!rst && busA.out_valid && busA.out_ready) begin
      if (expQA.size() == 0) begin
        total++; bad++;
        $display("FAIL a_extra_beat actual=%0h required=none", {busA.out_last, busA.out_data});
      end else begin
        check("a_out", 64'({busA.out_last, busA.out_data}), 64'(expQA.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && busB.out_valid && busB.out_ready) begin
      if (expQB.size() == 0) begin
        total++; bad++;
        $display("FAIL b_extra_beat actual=%0h required=none", {busB.out_last, busB.out_data});
      end else begin
        check("b_out", 64'({busB.out_last, busB.out_data}), 64'(expQB.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && busC.out_valid && busC.out_ready) begin
      if (expQC.size() == 0) begin
        total++; bad++;
        $display("FAIL c_extra_beat actual=%0h required=none", {busC.out_last, busC.out_data});
      end else begin
        check("c_out", 64'({busC.out_last, busC.out_data}), 64'(expQC.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pushA(input int v, input bit last);
    expQA.push_back({last, 32'(v)});
  endtask

  task automatic pushB(input int v, input bit last);
    expQB.push_back({last, 16'(v)});
  endtask

  task automatic pushC(input int v, input bit last);
    expQC.push_back({last, 32'(v)});
  endtask

  task automatic writeA(input int idx, input int v);
    busA.w_we = 1'b1; busA.w_idx = 2'(idx); busA.w_data = 32'(v);
    tick();
    busA.w_we = 1'b0;
  endtask

  task automatic sendA(input int v, input bit last);
    bit fired = 1'b0;
    busA.in_valid = 1'b1; busA.in_data = 32'(v); busA.in_last = last;
    for (int i = 0; i < 50 && !fired; i++) begin
      @(negedge clk);
      fired = busA.in_ready;
      tick();
    end
    busA.in_valid = 1'b0; busA.in_last = 1'b0;
    if (!fired) begin
      total++; bad++;
      $display("FAIL a_fire_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic sendB(input int v, input bit last);
    bit fired = 1'b0;
    busB.in_valid = 1'b1; busB.in_data = 8'(v); busB.in_last = last;
    for (int i = 0; i < 50 && !fired; i++) begin
      @(negedge clk);
      fired = busB.in_ready;
      tick();
    end
    busB.in_valid = 1'b0; busB.in_last = 1'b0;
    if (!fired) begin
      total++; bad++;
      $display("FAIL b_fire_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic sendC(input int v, input bit last);
    bit fired = 1'b0;
    busC.in_valid = 1'b1; busC.in_data = 32'(v); busC.in_last = last;
    for (int i = 0; i < 50 && !fired; i++) begin
      @(negedge clk);
      fired = busC.in_ready;
      tick();
    end
    busC.in_valid = 1'b0; busC.in_last = 1'b0;
    if (!fired) begin
      total++; bad++;
      $display("FAIL c_fire_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic pushFrameA123;
    pushA(1, 0); pushA(3, 0); pushA(6, 0); pushA(6, 0); pushA(5, 0); pushA(3, 1);
  endtask

  task automatic sendOnesA;
    sendA(1, 0); sendA(1, 0); sendA(1, 0); sendA(1, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    busA.w_we = 0; busA.w_idx = '0; busA.w_data = '0;
    busA.in_valid = 0; busA.in_data = '0; busA.in_last = 0; busA.out_ready = 1;
    busB.w_we = 0; busB.w_idx = '0; busB.w_data = '0;
    busB.in_valid = 0; busB.in_data = '0; busB.in_last = 0; busB.out_ready = 1;
    busC.w_we = 0; busC.w_idx = '0; busC.w_data = '0;
    busC.in_valid = 0; busC.in_data = '0; busC.in_last = 0; busC.out_ready = 1;

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready_low", 64'(busA.in_ready), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready_high", 64'(busA.in_ready), 64'(1));
    check("rst_out_valid", 64'(busA.out_valid), 64'(0));
    check("rst_out_data", 64'(busA.out_data), 64'(0));
    check("rst_out_last", 64'(busA.out_last), 64'(0));
    check("rst_busy", 64'(busyA), 64'(0));
    check("rst_state", 64'(stateA), 64'(IDLE));
    tick();

    // Frame [1,1,1,1], w=[1,2,3], full throughput
    writeA(0, 1); writeA(1, 2); writeA(2, 3);
    pushFrameA123();
    sendOnesA();
    @(negedge clk);
    check("t1_busy_flush", 64'(busyA), 64'(1));
    check("t1_state_flush", 64'(stateA), 64'(FLUSH));
    repeat (3) tick();
    @(negedge clk);
    check("t1_drained_in_6", 64'(expQA.size()), 64'(0));
    check("t1_idle_busy", 64'(busyA), 64'(0));
    check("t1_out_valid_done", 64'(busA.out_valid), 64'(0));
    tick();

    // Same frame with 3 stall cycles at the 2nd output
    pushFrameA123();
    fork
      sendOnesA();
      begin
        tick(); tick();
        busA.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_hold_data", 64'(busA.out_data), 64'(3));
          check("bp_hold_valid", 64'(busA.out_valid), 64'(1));
          check("bp_in_ready", 64'(busA.in_ready), 64'(0));
          tick();
        end
        busA.out_ready = 1'b1;
      end
    join
    repeat (6) tick();
    @(negedge clk);
    check("bp_drained", 64'(expQA.size()), 64'(0));
    tick();

    // Weight write during RUN is ignored
    pushFrameA123();
    fork
      sendOnesA();
      begin
        tick();
        busA.w_we = 1'b1; busA.w_idx = 2'd1; busA.w_data = 32'd9;
        tick();
        busA.w_we = 1'b0;
      end
    join
    repeat (6) tick();
    @(negedge clk);
    check("wr_run_drained", 64'(expQA.size()), 64'(0));
    tick();

    // Same write in IDLE applies: frame [1] -> 1,9,3
    writeA(1, 9);
    pushA(1, 0); pushA(9, 0); pushA(3, 1);
    sendA(1, 1);
    repeat (4) tick();
    @(negedge clk);
    check("wr_idle_drained", 64'(expQA.size()), 64'(0));
    tick();

    // Write in the same cycle as the first fire: frame [1] -> 1,2,3
    busA.w_we = 1'b1; busA.w_idx = 2'd1; busA.w_data = 32'd2;
    pushA(1, 0); pushA(2, 0); pushA(3, 1);
    sendA(1, 1);
    busA.w_we = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("wr_same_drained", 64'(expQA.size()), 64'(0));
    tick();

    // rst after two samples discards partial state and the pending output
    pushA(1, 0);
    sendA(1, 0); sendA(1, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", 64'(busA.in_ready), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 64'(busA.out_valid), 64'(0));
    check("rst_mid_out_data", 64'(busA.out_data), 64'(0));
    check("rst_mid_busy", 64'(busyA), 64'(0));
    tick();
    pushA(2, 0); pushA(4, 0); pushA(6, 1);
    sendA(2, 1);
    repeat (4) tick();
    @(negedge clk);
    check("rst_frame_drained", 64'(expQA.size()), 64'(0));
    tick();

    // Narrowing: DW=WW=8, OUT_W=16, w=127 x3, x=[127,127,127]
    for (int k = 0; k < 3; k++) begin
      busB.w_we = 1'b1; busB.w_idx = 2'(k); busB.w_data = 8'sd127;
      tick();
    end
    busB.w_we = 1'b0;
    pushB(16129, 0); pushB(32258, 0);
`ifdef CONV1D_SAT_EN
    pushB(32767, 0);
`else
    pushB(-17149, 0);
`endif
    pushB(32258, 0); pushB(16129, 1);
    sendB(127, 0); sendB(127, 0); sendB(127, 1);
    repeat (6) tick();
    @(negedge clk);
    check("b_drained", 64'(expQB.size()), 64'(0));
    tick();

    // TAPS=1: w=-5, frame [3,-4] -> -15, 20 with no flush
    busC.w_we = 1'b1; busC.w_idx = 1'b0; busC.w_data = -32'sd5;
    tick();
    busC.w_we = 1'b0;
    pushC(-15, 0); pushC(20, 1);
    sendC(3, 0); sendC(-4, 1);
    @(negedge clk);
    check("c_idle_after_last", 64'(stateC), 64'(IDLE));
    check("c_last_valid", 64'(busC.out_valid), 64'(1));
    tick();
    @(negedge clk);
    check("c_no_flush_beat", 64'(busC.out_valid), 64'(0));
    check("c_drained", 64'(expQC.size()), 64'(0));
    tick();

    repeat (4) tick();
    check("end_a_empty", 64'(expQA.size()), 64'(0));
    check("end_b_idle", 64'(busyB), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
